// File: rtl/dram_rd_fetch.sv
// dram_rd_fetch: strided single-word DRAM read burst engine. Outstanding reads are
// credit-limited against a first-word fall-through return FIFO, so returns never overflow it.
module dram_rd_fetch #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 18,
    parameter int unsigned LEN_WIDTH    = 12,
    parameter int unsigned STRIDE_WIDTH = 10,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_WIDTH-1:0]   base_addr,
    input  logic [LEN_WIDTH-1:0]    len,
    input  logic [STRIDE_WIDTH-1:0] stride,
    output logic                    busy,
    output logic                    done,
    output logic                    dram_en_rd,
    output logic [ADDR_WIDTH-1:0]   dram_addr_rd,
    input  logic                    dram_valid,
    input  logic [DATA_WIDTH-1:0]   dram_data_rd,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready
);

    // FIFO_DEPTH is a power of two >= 2, so pointers wrap naturally.
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StDone} state_e;

    state_e                  state_q, state_d;
    logic [LEN_WIDTH-1:0]    len_q;
    logic [STRIDE_WIDTH-1:0] stride_q;
    logic [ADDR_WIDTH-1:0]   next_addr_q;
    logic [LEN_WIDTH-1:0]    issued_q;
    logic [LEN_WIDTH-1:0]    popped_q;
    logic [CntW-1:0]         inflight_q;
    logic                    en_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    busy_q;
    logic                    done_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]         wr_ptr_q;
    logic [PtrW-1:0]         rd_ptr_q;
    logic [CntW-1:0]         count_q;
    logic [DATA_WIDTH-1:0]   last_q;

    logic            start_accept;
    logic            active;
    logic            push_req;
    logic            push;
    logic            pop;
    logic            fifo_full;
    logic [CntW:0]   occupancy;
    logic            credit_ok;
    logic            issue;
    logic            last_issue;

    assign start_accept = (state_q == StIdle) && start && !done_q;
    assign active       = (state_q == StFetch) || (state_q == StDrain);
    assign push_req     = dram_valid && active;
    assign fifo_full    = (count_q == CntW'(FIFO_DEPTH));
    assign pop          = out_valid && out_ready;
    // A full FIFO can still take a return in a cycle that also pops.
    assign push         = push_req && (!fifo_full || pop);

    // A pop this cycle frees a slot before any new request can return (latency >= 1),
    // so it is credited immediately; this keeps 1 word/cycle up to latency FIFO_DEPTH-1.
    assign occupancy  = {1'b0, inflight_q} + {1'b0, count_q} - {{CntW{1'b0}}, pop};
    assign credit_ok  = (occupancy < (CntW + 1)'(FIFO_DEPTH));
    assign issue      = (state_q == StFetch) && (issued_q < len_q) && credit_ok;
    assign last_issue = issue && (issued_q == len_q - LEN_WIDTH'(1));

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_accept) begin
                    state_d = (len == '0) ? StDone : StFetch;
                end
            end
            StFetch: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if ((inflight_q == '0) && (count_q == '0) && (popped_q == len_q)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State, burst parameters, issue/pop/in-flight counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            stride_q    <= '0;
            next_addr_q <= '0;
            issued_q    <= '0;
            popped_q    <= '0;
            inflight_q  <= '0;
            en_q        <= 1'b0;
            addr_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == StFetch) || (state_d == StDrain);
            // done trails the DONE state by one cycle; start is held off while it is high.
            done_q  <= (state_q == StDone);
            en_q    <= issue;

            if (start_accept) begin
                len_q       <= len;
                stride_q    <= stride;
                next_addr_q <= base_addr;
                issued_q    <= '0;
                popped_q    <= '0;
            end else begin
                if (issue) begin
                    addr_q      <= next_addr_q;
                    next_addr_q <= next_addr_q + ADDR_WIDTH'(stride_q);
                    issued_q    <= issued_q + LEN_WIDTH'(1);
                end
                if (pop) begin
                    popped_q <= popped_q + LEN_WIDTH'(1);
                end
            end

            if (issue && !push_req) begin
                inflight_q <= inflight_q + CntW'(1);
            end else if (!issue && push_req) begin
                inflight_q <= inflight_q - CntW'(1);
            end
        end
    end

    // Return FIFO storage, pointers and occupancy; last_q keeps the most recent head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= dram_data_rd;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            count_q <= count_q + CntW'(push) - CntW'(pop);
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign dram_en_rd   = en_q;
    assign dram_addr_rd = addr_q;
    assign out_valid    = (count_q != '0);
    assign out_data     = out_valid ? mem_q[rd_ptr_q] : last_q;

    // A return arriving with the FIFO full and no pop would be lost.
    assert property (@(posedge clk) disable iff (rst) !(push_req && fifo_full && !pop));

endmodule

// File: tb/tb_dram_rd_fetch.sv
// Bench for dram_rd_fetch: latency-configurable DRAM model, queue-based expected address/data
// stream per burst, vector table plus hand-written credit, len=0, busy-start and reset sequences.
module tb_dram_rd_fetch;

    localparam int DW    = 32;
    localparam int AW    = 18;
    localparam int LW    = 12;
    localparam int SW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [LW-1:0] len;
    logic [SW-1:0] stride;
    logic          busy;
    logic          done;
    logic          dram_en_rd;
    logic [AW-1:0] dram_addr_rd;
    logic          dram_valid;
    logic [DW-1:0] dram_data_rd;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready;

    always #5 clk = ~clk;

    dram_rd_fetch #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .LEN_WIDTH   (LW),
        .STRIDE_WIDTH(SW),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .base_addr   (base_addr),
        .len         (len),
        .stride      (stride),
        .busy        (busy),
        .done        (done),
        .dram_en_rd  (dram_en_rd),
        .dram_addr_rd(dram_addr_rd),
        .dram_valid  (dram_valid),
        .dram_data_rd(dram_data_rd),
        .out_valid   (out_valid),
        .out_data    (out_data),
        .out_ready   (out_ready)
    );

    int checks   = 0;
    int failures = 0;

    // Expected stream for the current burst.
    logic [AW-1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    int            n_iss, n_pop, n_done, n_busy_hi, cyc, first_iss, last_iss, max_out;
    logic [AW-1:0] last_addr_seen;
    int            cur_lat, rdy_mode, stray_n;

    // DRAM return pipeline: slot 0 is presented on the next step.
    logic          pv [DEPTH];
    logic [AW-1:0] pa [DEPTH];

    typedef struct {
        logic [AW-1:0] base;
        int            ln;
        logic [SW-1:0] str;
        int            lat;
        int            rmode;
        logic [AW-1:0] last_a;
        int            span;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return (DW'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // One clock: drive inputs at the falling edge, then sample the DUT's current-cycle outputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        case (rdy_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
        dram_valid   = pv[0];
        dram_data_rd = pv[0] ? mem_word(pa[0]) : '0;
        if (stray_n > 0 && !pv[0]) begin
            dram_valid   = 1'b1;
            dram_data_rd = 32'hDEAD_BEEF;
            stray_n--;
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            pv[i] = pv[i + 1];
            pa[i] = pa[i + 1];
        end
        pv[DEPTH - 1]  = 1'b0;
        pv[cur_lat - 1] = dram_en_rd && !rst;
        pa[cur_lat - 1] = dram_addr_rd;
        if (!rst) begin
            if (dram_en_rd) begin
                if (n_iss < exp_addr.size()) chk("rd_addr", 64'(dram_addr_rd), 64'(exp_addr[n_iss]));
                else                         chk("extra_read", 1, 0);
                if (first_iss < 0) first_iss = cyc;
                last_iss       = cyc;
                last_addr_seen = dram_addr_rd;
                n_iss++;
            end
            if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
            if (out_valid && out_ready) begin
                if (n_pop < exp_data.size()) chk("out_data", 64'(out_data), 64'(exp_data[n_pop]));
                else                         chk("extra_pop", 1, 0);
                n_pop++;
            end
            if (done) begin
                n_done++;
                chk("busy_at_done", 64'(busy), 0);
            end
            if (busy) n_busy_hi++;
        end
    endtask

    task automatic begin_burst(input logic [AW-1:0] b, input int ln, input logic [SW-1:0] s,
                               input int lat, input int rmode);
        logic [31:0] acc;
        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < ln; i++) begin
            acc = 32'(b) + 32'(i) * 32'(s);
            exp_addr.push_back(acc[AW-1:0]);
            exp_data.push_back(mem_word(acc[AW-1:0]));
        end
        n_iss = 0; n_pop = 0; n_done = 0; n_busy_hi = 0; max_out = 0;
        first_iss = -1; last_iss = -1; last_addr_seen = '0;
        cur_lat = lat; rdy_mode = rmode;
        base_addr = b; len = LW'(ln); stride = s;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 64'(busy), 64'(ln != 0));
    endtask

    task automatic finish_burst(input int ln, input int span, input logic [AW-1:0] last_a,
                                input bit chk_last);
        int t;
        t = 0;
        while (n_done == 0 && t < 3000) begin
            step();
            t++;
        end
        chk("done_seen", 64'(n_done != 0), 1);
        repeat (4) step();
        chk("reads", 64'(n_iss), 64'(ln));
        chk("pops", 64'(n_pop), 64'(ln));
        chk("done_once", 64'(n_done), 1);
        chk("busy_after", 64'(busy), 0);
        chk("credit", 64'(max_out <= DEPTH), 1);
        if (span >= 0) chk("issue_span", 64'(last_iss - first_iss), 64'(span));
        if (chk_last)  chk("last_addr", 64'(last_addr_seen), 64'(last_a));
    endtask

    initial begin
        tbl[0] = '{18'h00100, 4,  10'd1,  1, 1, 18'h00103, 3};
        tbl[1] = '{18'h3FFF0, 3,  10'd28, 1, 1, 18'h00028, 2};
        tbl[2] = '{18'h00050, 50, 10'd1,  3, 2, 18'h00081, -1};
        tbl[3] = '{18'h01000, 16, 10'd7,  5, 1, 18'h01069, 15};

        for (int i = 0; i < DEPTH; i++) begin
            pv[i] = 1'b0;
            pa[i] = '0;
        end
        cyc = 0; stray_n = 0; cur_lat = 1; rdy_mode = 1;
        n_iss = 0; n_pop = 0; n_done = 0; n_busy_hi = 0; max_out = 0;
        first_iss = -1; last_iss = -1; last_addr_seen = '0;
        rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; stride = '0;
        dram_valid = 1'b0; dram_data_rd = '0; out_ready = 1'b0;
        repeat (3) step();
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_en_rd", 64'(dram_en_rd), 0);
        chk("rst_addr", 64'(dram_addr_rd), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        rst = 1'b0;
        repeat (2) step();

        // Vector table: base/len/stride/latency/ready mode with hand-computed last address.
        for (int v = 0; v < 4; v++) begin
            begin_burst(tbl[v].base, tbl[v].ln, tbl[v].str, tbl[v].lat, tbl[v].rmode);
            finish_burst(tbl[v].ln, tbl[v].span, tbl[v].last_a, 1'b1);
        end

        // Consumer stalled: credit caps reads at DEPTH, then a start while busy is ignored.
        begin_burst(18'h00200, 20, 10'd1, 2, 0);
        repeat (40) step();
        chk("stall_reads", 64'(n_iss), DEPTH);
        chk("stall_en_rd", 64'(dram_en_rd), 0);
        chk("stall_out_valid", 64'(out_valid), 1);
        base_addr = '0; len = LW'(5); stride = SW'(3);
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (5) step();
        chk("busy_start_ignored", 64'(n_iss), DEPTH);
        rdy_mode = 1;
        finish_burst(20, -1, 18'h00213, 1'b1);

        // len == 0: no reads, no busy, done exactly two cycles after the start cycle.
        begin_burst(18'h00400, 0, 10'd1, 1, 1);
        chk("len0_done_early", 64'(done), 0);
        step();
        chk("len0_done", 64'(done), 1);
        step();
        chk("len0_done_once", 64'(done), 0);
        repeat (3) step();
        chk("len0_reads", 64'(n_iss), 0);
        chk("len0_busy", 64'(n_busy_hi), 0);

        // Randomised bursts against the queue model.
        for (int r = 0; r < 4; r++) begin
            begin_burst(AW'($urandom), int'($urandom_range(1, 40)), SW'($urandom),
                        int'($urandom_range(1, 7)), 2);
            finish_burst(exp_addr.size(), -1, '0, 1'b0);
        end

        // Reset mid-FETCH: immediate clear, stale and stray returns dropped, then a clean burst.
        begin_burst(18'h00300, 20, 10'd1, 2, 1);
        repeat (5) step();
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_done", 64'(done), 0);
        chk("abort_en_rd", 64'(dram_en_rd), 0);
        chk("abort_addr", 64'(dram_addr_rd), 0);
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_out_data", 64'(out_data), 0);
        repeat (2) step();
        rst = 1'b0;
        stray_n = 3;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("stray_out_valid", 64'(out_valid), 0);
            chk("stray_busy", 64'(busy), 0);
        end
        chk("abort_no_done", 64'(n_done), 0);
        begin_burst(18'h00040, 2, 10'd3, 1, 1);
        finish_burst(2, 1, 18'h00043, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
